// File: rtl/entrada_dados_if.sv
// Processor/board-facing signal bundle of the IN-instruction input unit.
// The master side drives the request and the raw switch/key pins; the slave side returns the value.
interface entrada_dados_if #(
    parameter int unsigned MAG_W = 10
);
    logic             InRead;
    logic [MAG_W-1:0] Switches;
    logic             SignSw;
    logic             KeyN;
    logic [31:0]      Dado;
    logic             Ready;
    logic             Waiting;

    modport master (
        output InRead,
        output Switches,
        output SignSw,
        output KeyN,
        input  Dado,
        input  Ready,
        input  Waiting
    );

    modport slave (
        input  InRead,
        input  Switches,
        input  SignSw,
        input  KeyN,
        output Dado,
        output Ready,
        output Waiting
    );
endinterface

// File: rtl/entrada_dados.sv
// IN-instruction input unit: stalls the core until a debounced key press confirms the
// sign-magnitude switch value, then returns it as a 32-bit two's-complement word.
module entrada_dados #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned MAG_W      = 10
) (
    input logic            CLK,
    input logic            Reset,
    entrada_dados_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StDone,
        StWaitRelease
    } state_e;

    logic            key_s1;
    logic            key_s2;
    logic            key_deb;
    logic            key_deb_prev;
    logic [CntW-1:0] deb_cnt;
    logic            press;

    state_e          state_q;
    logic [31:0]     dado_q;
    logic            ready_q;
    logic            waiting_q;
    logic            pending_q;

    logic [31:0]     mag;
    logic [31:0]     captured;

    // Key conditioning: 2-FF synchronizer, then the debounced level only follows a level
    // that has differed from it for DEB_CYCLES consecutive cycles.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            key_s1       <= 1'b1;
            key_s2       <= 1'b1;
            key_deb      <= 1'b1;
            key_deb_prev <= 1'b1;
            deb_cnt      <= '0;
        end else begin
            key_s1       <= bus.KeyN;
            key_s2       <= key_s1;
            key_deb_prev <= key_deb;
            if (key_s2 == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CntW'(DEB_CYCLES - 1)) begin
                key_deb <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press    = key_deb_prev & ~key_deb;
    assign mag      = {{(32 - MAG_W){1'b0}}, bus.Switches};
    assign captured = bus.SignSw ? (~mag + 32'd1) : mag;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StIdle;
            dado_q    <= '0;
            ready_q   <= 1'b0;
            waiting_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.InRead || pending_q) begin
                        state_q   <= StWaitPress;
                        waiting_q <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StWaitPress: begin
                    if (press) begin
                        state_q   <= StDone;
                        dado_q    <= captured;
                        ready_q   <= 1'b1;
                        waiting_q <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StWaitRelease;
                    ready_q <= 1'b0;
                    if (bus.InRead) pending_q <= 1'b1;
                end
                StWaitRelease: begin
                    // A request here is deferred so the still-held key cannot answer it.
                    if (bus.InRead) pending_q <= 1'b1;
                    if (key_deb) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Dado    = dado_q;
    assign bus.Ready   = ready_q;
    assign bus.Waiting = waiting_q;

endmodule

// File: tb/tb_entrada_dados.sv
// Bench for entrada_dados: a cycle-level behavioural model compared every cycle against the DUT,
// plus directed scenarios with hand-computed literal expectations.
module tb_entrada_dados;

    localparam int unsigned DebCycles = 4;
    localparam int unsigned MagW      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    entrada_dados_if #(.MAG_W(MagW)) bus ();

    entrada_dados #(
        .DEB_CYCLES(DebCycles),
        .MAG_W     (MagW)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the user-visible transaction phase plus the key history the debouncer sees.
    typedef struct packed {
        logic                 ready;
        logic                 waiting;
        logic                 held;
        logic                 pending;
        logic                 deb;
        logic                 fell;
        logic                 d1;
        logic                 d2;
        logic [31:0]          dado;
        logic [DebCycles-1:0] hist;
        logic [3:0]           nvalid;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_init();
        mstate_t s;
        s.ready   = 1'b0;
        s.waiting = 1'b0;
        s.held    = 1'b0;
        s.pending = 1'b0;
        s.deb     = 1'b1;
        s.fell    = 1'b0;
        s.d1      = 1'b1;
        s.d2      = 1'b1;
        s.dado    = '0;
        s.hist    = '0;
        s.nvalid  = '0;
        return s;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic r, input logic inread,
                                           input logic [MagW-1:0] sw, input logic sign,
                                           input logic keyn);
        mstate_t n;
        int      v;
        logic    lv;
        bit      flip;
        if (r) return model_init();
        n = s;
        if (s.waiting) begin
            if (s.fell) begin
                v = int'(sw);
                if (sign) v = -v;
                n.dado    = 32'(v);
                n.ready   = 1'b1;
                n.waiting = 1'b0;
                n.held    = 1'b1;
            end
        end else if (s.ready) begin
            n.ready = 1'b0;
            if (inread) n.pending = 1'b1;
        end else if (s.held) begin
            if (inread) n.pending = 1'b1;
            if (s.deb) n.held = 1'b0;
        end else if (inread || s.pending) begin
            n.waiting = 1'b1;
            n.pending = 1'b0;
        end
        // The debouncer sees the pin two samples late; it flips after DebCycles opposing samples.
        lv   = s.d2;
        n.d2 = s.d1;
        n.d1 = keyn;
        n.hist = {s.hist[DebCycles-2:0], lv};
        if (s.nvalid < 4'(DebCycles)) n.nvalid = s.nvalid + 4'd1;
        flip = (n.nvalid >= 4'(DebCycles)) && (n.hist == {DebCycles{~s.deb}});
        n.fell = flip && s.deb;
        if (flip) begin
            n.deb    = ~s.deb;
            n.nvalid = '0;
        end
        return n;
    endfunction

    initial m = model_init();

    always @(posedge clk) begin
        m <= model_step(m, rst, bus.InRead, bus.Switches, bus.SignSw, bus.KeyN);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", 32'(bus.Ready), 32'(m.ready));
            check("waiting", 32'(bus.Waiting), 32'(m.waiting));
            check("dado", bus.Dado, m.dado);
            if (bus.Ready === 1'b1) rdy_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic request();
        bus.InRead = 1'b1;
        step(1);
        bus.InRead = 1'b0;
    endtask

    task automatic key_press(input int low_n, input int high_n);
        bus.KeyN = 1'b0;
        step(low_n);
        bus.KeyN = 1'b1;
        step(high_n);
    endtask

    int r0;

    initial begin
        bus.InRead   = 1'b0;
        bus.Switches = '0;
        bus.SignSw   = 1'b0;
        bus.KeyN     = 1'b1;
        rst          = 1'b1;
        step(1);
        cmp_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        check("reset_ready", 32'(bus.Ready), 32'd0);
        check("reset_dado", bus.Dado, 32'd0);

        // Reset in the middle of a pending request.
        request();
        step(2);
        check("t1_waiting_before", 32'(bus.Waiting), 32'd1);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check("t1_waiting", 32'(bus.Waiting), 32'd0);
        check("t1_ready", 32'(bus.Ready), 32'd0);
        check("t1_dado", bus.Dado, 32'd0);
        r0 = rdy_cnt;
        step(10);
        check("t1_idle_waiting", 32'(bus.Waiting), 32'd0);
        check("t1_no_ready", 32'(rdy_cnt - r0), 32'd0);

        // Positive value.
        bus.Switches = 10'd123;
        bus.SignSw   = 1'b0;
        r0 = rdy_cnt;
        request();
        check("t2_waiting", 32'(bus.Waiting), 32'd1);
        key_press(10, 10);
        check("t2_one_ready", 32'(rdy_cnt - r0), 32'd1);
        check("t2_dado", bus.Dado, 32'd123);
        check("t2_waiting_drop", 32'(bus.Waiting), 32'd0);

        // Negative value and negative zero.
        bus.Switches = 10'd5;
        bus.SignSw   = 1'b1;
        request();
        key_press(10, 10);
        check("t3_neg5", bus.Dado, 32'hFFFF_FFFB);
        check("t3_model_neg5", m.dado, 32'hFFFF_FFFB);
        bus.Switches = 10'd0;
        request();
        key_press(10, 10);
        check("t3_negzero", bus.Dado, 32'h0000_0000);

        // Short glitches never reach the debounced level.
        bus.Switches = 10'd9;
        bus.SignSw   = 1'b0;
        r0 = rdy_cnt;
        request();
        for (int i = 0; i < 5; i++) begin
            bus.KeyN = 1'b0;
            step(2);
            bus.KeyN = 1'b1;
            step(3);
        end
        check("t4_glitch_no_ready", 32'(rdy_cnt - r0), 32'd0);
        check("t4_glitch_waiting", 32'(bus.Waiting), 32'd1);
        key_press(10, 10);
        check("t4_clean_ready", 32'(rdy_cnt - r0), 32'd1);
        check("t4_dado", bus.Dado, 32'd9);

        // A press with no request is ignored.
        bus.Switches = 10'd77;
        r0 = rdy_cnt;
        key_press(10, 10);
        check("t5_idle_press", 32'(rdy_cnt - r0), 32'd0);
        check("t5_dado_kept", bus.Dado, 32'd9);
        bus.Switches = 10'd1023;
        bus.SignSw   = 1'b1;
        request();
        key_press(10, 10);
        check("t5_min", bus.Dado, 32'hFFFF_FC01);
        check("t5_model_min", m.dado, 32'hFFFF_FC01);

        // Request while the key is still held is served only after release and a new press.
        bus.Switches = 10'd42;
        bus.SignSw   = 1'b0;
        r0 = rdy_cnt;
        request();
        bus.KeyN = 1'b0;
        step(10);
        check("t6_first_ready", 32'(rdy_cnt - r0), 32'd1);
        check("t6_dado", bus.Dado, 32'd42);
        request();
        step(10);
        check("t6_held_no_ready", 32'(rdy_cnt - r0), 32'd1);
        check("t6_held_waiting", 32'(bus.Waiting), 32'd0);
        bus.KeyN = 1'b1;
        step(10);
        check("t6_pending_served", 32'(bus.Waiting), 32'd1);
        check("t6_still_one", 32'(rdy_cnt - r0), 32'd1);
        bus.Switches = 10'd100;
        bus.SignSw   = 1'b1;
        key_press(10, 10);
        check("t6_second_ready", 32'(rdy_cnt - r0), 32'd2);
        check("t6_dado2", bus.Dado, 32'hFFFF_FF9C);
        step(5);
        check("t6_exactly_one_more", 32'(rdy_cnt - r0), 32'd2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
